// File: rtl/parallel_pe_if.sv
// Beat/result bus of the multi-lane PE: packed neuron/weight lanes, vector control and
// mode in, signed vector result out, each side with its own ready/valid pair.
interface parallel_pe_if #(
  parameter int LANES  = 4,
  parameter int DATA_W = 16,
  parameter int RES_W  = 32
);
  logic [LANES*DATA_W-1:0] neuron_i;
  logic [LANES*DATA_W-1:0] weight_i;
  logic [1:0]              ctl_i;
  logic [1:0]              mode_i;
  logic                    vld_i;
  logic                    rdy_o;
  logic [RES_W-1:0]        result_o;
  logic                    vld_o;
  logic                    rdy_i;

  modport slave (
    input  neuron_i, weight_i, ctl_i, mode_i, vld_i, rdy_i,
    output rdy_o, result_o, vld_o
  );

  modport master (
    output neuron_i, weight_i, ctl_i, mode_i, vld_i, rdy_i,
    input  rdy_o, result_o, vld_o
  );
endinterface

// File: rtl/parallel_pe.sv
// Multi-lane MAC: per-beat lane products, adder-tree reduction, vector accumulation
// and wrap/saturate/ReLU conversion, three register stages under one global stall.
module parallel_pe #(
  parameter int LANES  = 4,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 48,
  parameter int RES_W  = 32
) (
  input logic           clk,
  input logic           rst,
  parallel_pe_if.slave  bus
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int NODES  = 2 * LANES - 1;

  localparam logic signed [ACC_W-1:0] RES_MAX = {{(ACC_W-RES_W+1){1'b0}}, {(RES_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] RES_MIN = {{(ACC_W-RES_W+1){1'b1}}, {(RES_W-1){1'b0}}};
  localparam logic [RES_W-1:0] OUT_MAX = {1'b0, {(RES_W-1){1'b1}}};
  localparam logic [RES_W-1:0] OUT_MIN = {1'b1, {(RES_W-1){1'b0}}};

  // A held result blocks the whole pipe; upstream sees it combinationally.
  logic stall;
  assign stall     = bus.vld_o & ~bus.rdy_i;
  assign bus.rdy_o = ~stall;

  // Stage 1: lane products
  logic signed [PROD_W-1:0] prod_d [LANES];
  logic signed [PROD_W-1:0] prod_q [LANES];
  logic                     s1_vld_q;
  logic [1:0]               s1_ctl_q;
  logic [1:0]               s1_mode_q;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_mul
    logic signed [DATA_W-1:0] n_lane;
    logic signed [DATA_W-1:0] w_lane;
    assign n_lane     = bus.neuron_i[(LANES-1-gi)*DATA_W +: DATA_W];
    assign w_lane     = bus.weight_i[(LANES-1-gi)*DATA_W +: DATA_W];
    assign prod_d[gi] = PROD_W'(n_lane) * PROD_W'(w_lane);
  end

  // Stage 2: heap-ordered adder tree, leaves at LANES-1.., root at node 0
  logic signed [ACC_W-1:0] tree [NODES];
  logic signed [ACC_W-1:0] sum_d;
  logic signed [ACC_W-1:0] sum_q;
  logic                    s2_vld_q;
  logic [1:0]              s2_ctl_q;
  logic [1:0]              s2_mode_q;

  always_comb begin
    for (int k = 0; k < NODES; k++) tree[k] = '0;
    for (int k = 0; k < LANES; k++) tree[LANES-1+k] = ACC_W'(prod_q[k]);
    for (int k = LANES - 2; k >= 0; k--) tree[k] = tree[2*k+1] + tree[2*k+2];
    sum_d = tree[0];
  end

  // Stage 3: accumulator, vector mode and output register
  logic signed [ACC_W-1:0] acc_d;
  logic signed [ACC_W-1:0] acc_q;
  logic [1:0]              mode_q;
  logic [1:0]              eff_mode;
  logic [RES_W-1:0]        res_d;
  logic [RES_W-1:0]        result_q;
  logic                    vld_o_q;

  always_comb begin
    eff_mode = s2_ctl_q[0] ? s2_mode_q : mode_q;
    acc_d    = s2_ctl_q[0] ? sum_q : acc_q + sum_q;
    res_d    = acc_d[RES_W-1:0];
    if (eff_mode != 2'd0) begin
      if (acc_d > RES_MAX) begin
        res_d = OUT_MAX;
      end else if (acc_d < RES_MIN) begin
        res_d = (eff_mode == 2'd2) ? '0 : OUT_MIN;
      end else if (eff_mode == 2'd2 && acc_d[ACC_W-1]) begin
        res_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
      acc_q    <= '0;
      mode_q   <= '0;
      result_q <= '0;
      vld_o_q  <= 1'b0;
    end else if (!stall) begin
      s1_vld_q  <= bus.vld_i;
      s1_ctl_q  <= bus.ctl_i;
      s1_mode_q <= bus.mode_i;
      for (int k = 0; k < LANES; k++) prod_q[k] <= prod_d[k];

      s2_vld_q  <= s1_vld_q;
      s2_ctl_q  <= s1_ctl_q;
      s2_mode_q <= s1_mode_q;
      sum_q     <= sum_d;

      if (s2_vld_q) begin
        acc_q <= acc_d;
        if (s2_ctl_q[0]) mode_q <= s2_mode_q;
      end
      // Not stalled means any pending result is being taken this cycle.
      if (s2_vld_q && s2_ctl_q[1]) begin
        result_q <= res_d;
        vld_o_q  <= 1'b1;
      end else begin
        vld_o_q  <= 1'b0;
      end
    end
  end

  assign bus.result_o = result_q;
  assign bus.vld_o    = vld_o_q;

endmodule

// File: tb/tb_parallel_pe.sv
// Scoreboard bench for parallel_pe: a dot-product/accumulate model queues expected
// results at beat acceptance, a monitor pops and compares on every result handshake.
module tb_parallel_pe;
  localparam int LANES  = 4;
  localparam int DATA_W = 16;
  localparam int ACC_W  = 48;
  localparam int RES_W  = 32;
  localparam int BW     = LANES * DATA_W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  parallel_pe_if #(.LANES(LANES), .DATA_W(DATA_W), .RES_W(RES_W)) bus ();

  parallel_pe #(.LANES(LANES), .DATA_W(DATA_W), .ACC_W(ACC_W), .RES_W(RES_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_pops  = 0;
  logic [RES_W-1:0] exp_q [$];
  logic [RES_W-1:0] last_result = '0;
  logic signed [ACC_W-1:0] m_acc = '0;
  logic [1:0] m_mode = 2'd0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [RES_W-1:0] convert(input logic signed [ACC_W-1:0] a, input logic [1:0] mode);
    longint v;
    longint hi;
    longint lo;
    hi = (longint'(1) <<< (RES_W - 1)) - 1;
    lo = -(longint'(1) <<< (RES_W - 1));
    v  = longint'(a);
    if (mode == 2'd0) return a[RES_W-1:0];
    if (v > hi) v = hi;
    else if (v < lo) v = lo;
    if (mode == 2'd2 && v < 0) v = 0;
    return v[RES_W-1:0];
  endfunction

  // Reference: plain dot product, accumulate, convert at vector end.
  task automatic model_beat(input logic [BW-1:0] nv, input logic [BW-1:0] wv,
                            input logic [1:0] ctl, input logic [1:0] mode);
    longint dot = 0;
    for (int l = 0; l < LANES; l++) begin
      logic signed [DATA_W-1:0] n;
      logic signed [DATA_W-1:0] w;
      n = nv[(LANES-1-l)*DATA_W +: DATA_W];
      w = wv[(LANES-1-l)*DATA_W +: DATA_W];
      dot += longint'(n) * longint'(w);
    end
    if (ctl[0]) begin
      m_acc  = ACC_W'(dot);
      m_mode = mode;
    end else begin
      m_acc = m_acc + ACC_W'(dot);
    end
    if (ctl[1]) exp_q.push_back(convert(m_acc, m_mode));
  endtask

  task automatic send_beat(input logic [BW-1:0] nv, input logic [BW-1:0] wv,
                           input logic [1:0] ctl, input logic [1:0] mode);
    bit ok = 1'b0;
    bus.neuron_i = nv;
    bus.weight_i = wv;
    bus.ctl_i    = ctl;
    bus.mode_i   = mode;
    bus.vld_i    = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      ok = bus.rdy_o;
      @(posedge clk);
      #1;
      if (ok) break;
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: got rdy_o=0, expected acceptance within 100 cycles");
    end else begin
      model_beat(nv, wv, ctl, mode);
    end
    bus.vld_i = 1'b0;
  endtask

  task automatic wait_drain();
    bit done = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !bus.vld_o) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending results, expected 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [BW-1:0] rep(input logic [DATA_W-1:0] e);
    return {LANES{e}};
  endfunction

  function automatic logic [BW-1:0] rnd_beat();
    logic [BW-1:0] b;
    for (int l = 0; l < LANES; l++) begin
      case ($urandom_range(0, 3))
        0:       b[l*DATA_W +: DATA_W] = 16'h7FFF;
        1:       b[l*DATA_W +: DATA_W] = 16'h8000;
        default: b[l*DATA_W +: DATA_W] = DATA_W'($urandom);
      endcase
    end
    return b;
  endfunction

  always @(negedge clk) begin
    if (!rst && bus.vld_o && bus.rdy_i) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_result: got 0x%08h, expected no result", bus.result_o);
      end else begin
        check("result", 64'(bus.result_o), 64'(exp_q.pop_front()));
      end
      $display("[TB] result 0x%08h", bus.result_o);
      last_result = bus.result_o;
      n_pops++;
    end
  end

  initial begin
    logic v1, v2, v3;
    int pops_before;
    bit rnd_done;

    rst = 1'b1;
    bus.neuron_i = '0;
    bus.weight_i = '0;
    bus.ctl_i    = '0;
    bus.mode_i   = '0;
    bus.vld_i    = 1'b0;
    bus.rdy_i    = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_vld_o", 64'(bus.vld_o), 0);
    check("reset_result_o", 64'(bus.result_o), 0);
    check("reset_rdy_o", 64'(bus.rdy_o), 1);
    @(posedge clk);
    #1;

    // 1: single beat, latency 3
    send_beat({16'd1, 16'd2, 16'd3, 16'd4}, {16'd5, 16'd6, 16'd7, 16'd8}, 2'b11, 2'd0);
    @(negedge clk) v1 = bus.vld_o;
    @(negedge clk) v2 = bus.vld_o;
    @(negedge clk) v3 = bus.vld_o;
    check("latency_c1", 64'(v1), 0);
    check("latency_c2", 64'(v2), 0);
    check("latency_c3", 64'(v3), 1);
    wait_drain();
    check("t1_dot", 64'(last_result), 64'h46);

    // 2: three-beat vectors, wrap and saturate
    send_beat(rep(16'h7FFF), rep(16'h7FFF), 2'b01, 2'd0);
    send_beat(rep(16'h7FFF), rep(16'h7FFF), 2'b00, 2'd0);
    send_beat(rep(16'h7FFF), rep(16'h7FFF), 2'b10, 2'd0);
    wait_drain();
    check("t2_wrap", 64'(last_result), 64'hFFF4000C);
    send_beat(rep(16'h7FFF), rep(16'h7FFF), 2'b01, 2'd1);
    send_beat(rep(16'h7FFF), rep(16'h7FFF), 2'b00, 2'd1);
    send_beat(rep(16'h7FFF), rep(16'h7FFF), 2'b10, 2'd1);
    wait_drain();
    check("t2_sat_pos", 64'(last_result), 64'h7FFFFFFF);
    send_beat(rep(16'h8000), rep(16'h7FFF), 2'b01, 2'd1);
    send_beat(rep(16'h8000), rep(16'h7FFF), 2'b00, 2'd1);
    send_beat(rep(16'h8000), rep(16'h7FFF), 2'b10, 2'd1);
    wait_drain();
    check("t2_sat_neg", 64'(last_result), 64'h80000000);

    // 3: negative result, ReLU, mode ignored on non-first beat
    send_beat(rep(16'hFFFF), rep(16'd100), 2'b11, 2'd1);
    wait_drain();
    check("t3_neg", 64'(last_result), 64'hFFFFFE70);
    send_beat(rep(16'hFFFF), rep(16'd100), 2'b11, 2'd2);
    wait_drain();
    check("t3_relu", 64'(last_result), 64'h0);
    send_beat(rep(16'hFFFF), rep(16'd100), 2'b01, 2'd2);
    send_beat(rep(16'hFFFF), rep(16'd100), 2'b10, 2'd0);
    wait_drain();
    check("t3_mode_latch", 64'(last_result), 64'h0);

    // 4a: 8 one-beat vectors streamed, results on 8 consecutive cycles
    fork
      begin
        for (int i = 0; i < 8; i++) send_beat(rnd_beat(), rnd_beat(), 2'b11, 2'($urandom_range(0, 3)));
      end
      begin
        int cnt = 0;
        int rises = 0;
        logic prev = 1'b0;
        for (int k = 0; k < 20; k++) begin
          @(negedge clk);
          if (bus.vld_o) cnt++;
          if (bus.vld_o && !prev) rises++;
          prev = bus.vld_o;
        end
        check("stream_count", 64'(cnt), 8);
        check("stream_contiguous", 64'(rises), 1);
      end
    join
    wait_drain();

    // 4b: same stream with 5 cycles of backpressure after the first result
    pops_before = n_pops;
    fork
      begin
        for (int i = 0; i < 8; i++) send_beat(rnd_beat(), rnd_beat(), 2'b11, 2'($urandom_range(0, 3)));
      end
      begin
        bit seen = 1'b0;
        logic [RES_W-1:0] held = '0;
        for (int k = 0; k < 30; k++) begin
          @(negedge clk);
          if (bus.vld_o) begin
            seen = 1'b1;
            break;
          end
        end
        check("stall_first_vld", 64'(seen), 1);
        @(posedge clk);
        #1 bus.rdy_i = 1'b0;
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          check("stall_rdy_o", 64'(bus.rdy_o), 0);
          check("stall_vld_o", 64'(bus.vld_o), 1);
          if (s == 0) held = bus.result_o;
          else check("stall_result_hold", 64'(bus.result_o), 64'(held));
        end
        @(posedge clk);
        #1 bus.rdy_i = 1'b1;
      end
    join
    wait_drain();
    check("stall_result_count", 64'(n_pops - pops_before), 8);

    // 5: reset mid-vector
    send_beat(rep(16'd7), rep(16'd9), 2'b01, 2'd1);
    send_beat(rep(16'd7), rep(16'd9), 2'b00, 2'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    m_acc  = '0;
    m_mode = 2'd0;
    exp_q.delete();
    @(negedge clk);
    check("midreset_vld_o", 64'(bus.vld_o), 0);
    check("midreset_rdy_o", 64'(bus.rdy_o), 1);
    check("midreset_result_o", 64'(bus.result_o), 0);
    @(posedge clk);
    #1;
    send_beat(rep(16'd1), rep(16'd1), 2'b11, 2'd0);
    wait_drain();
    check("after_reset", 64'(last_result), 64'd4);

    // 6: back-to-back two-beat vectors
    pops_before = n_pops;
    send_beat({16'd1, 16'd2, 16'd3, 16'd4}, rep(16'd1), 2'b01, 2'd0);
    send_beat({16'd1, 16'd2, 16'd3, 16'd4}, rep(16'd1), 2'b10, 2'd0);
    send_beat({16'd1, 16'd2, 16'd3, 16'd4}, rep(16'd1), 2'b01, 2'd0);
    send_beat({16'd1, 16'd2, 16'd3, 16'd4}, rep(16'd1), 2'b10, 2'd0);
    wait_drain();
    check("b2b_second", 64'(last_result), 64'd20);
    check("b2b_count", 64'(n_pops - pops_before), 2);

    // Random vectors under random backpressure
    rnd_done = 1'b0;
    fork
      begin
        for (int v = 0; v < 30; v++) begin
          int len = $urandom_range(1, 4);
          for (int b = 0; b < len; b++)
            send_beat(rnd_beat(), rnd_beat(), {b == len - 1, b == 0}, 2'($urandom_range(0, 3)));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1 bus.rdy_i = ($urandom_range(0, 3) != 0);
        end
        bus.rdy_i = 1'b1;
      end
    join
    wait_drain();
    check("queue_empty", 64'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/parallel_pe.md
# parallel_pe

Multi-lane successor to `serial_pe`. Each accepted beat carries `LANES` signed neuron/weight pairs. The block multiplies each pair, reduces the products through an adder tree, and accumulates the sum across a vector delimited by first/last control bits. At vector end it emits one result, either wrapped or saturated, with optional ReLU. It sits between the neuron/weight line buffers and the result writeback. It replaces the serial PE where throughput matters and adds a ready/valid handshake on both sides.

## Interface
- `LANES`, 4, multiply lanes per beat (power of two, ≥1)
- `DATA_W`, 16, signed width of each neuron/weight element
- `ACC_W`, 48, internal signed accumulator width (≥ 2*DATA_W + log2(LANES) + 1)
- `RES_W`, 32, signed output width (≤ ACC_W)

- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `neuron_i`  in  LANES*DATA_W  packed neurons, lane 0 in the MSBs
- `weight_i`  in  LANES*DATA_W  packed weights, lane 0 in the MSBs
- `ctl_i`  in  2  [0]=first beat of vector, [1]=last beat of vector
- `mode_i`  in  2  0=wrap, 1=saturate, 2=saturate+ReLU, 3=reserved (behaves as 1)
- `vld_i`  in  1  input beat valid
- `rdy_o`  out  1  input beat accepted when `vld_i & rdy_o`
- `result_o`  out  RES_W  signed vector result
- `vld_o`  out  1  result valid
- `rdy_i`  in  1  downstream accepts result when `vld_o & rdy_i`

## Operation
- Pipeline has three register stages, and each stage carries a valid bit plus the beat's ctl bits and mode:
  - S1: `LANES` signed products, each 2*DATA_W bits, sign-extended.
  - S2: the adder-tree sum of the S1 products, sign-extended to ACC_W.
  - S3: the accumulator and the output register.
- Accumulate rule at S3 for a valid beat:
  - With first set: `acc <= sum`.
  - Otherwise: `acc <= acc + sum`.
  - The ACC_W accumulator wraps silently.
  - A beat without first that follows reset or a completed vector accumulates onto the current `acc` (0 after reset, the previous value otherwise). Upstream is responsible for asserting first.
- On a valid beat with last set, the output register loads the converted value of the new accumulator and `vld_o` sets.
- Conversion of the new accumulator value:
  - Mode 0: the low RES_W bits.
  - Mode 1/3: clamp to [−2^(RES_W−1), 2^(RES_W−1)−1].
  - Mode 2: apply the mode 1 clamp, then force negative values to 0.
- The mode applied is the one latched with the vector's first beat. `mode_i` is ignored on other beats.
- A beat with both first and last set is a one-beat vector.
- Back-to-back vectors may be presented with no gap. The first beat of vector N+1 may immediately follow the last beat of vector N.
- Stall: `stall = vld_o & ~rdy_i`.
  - While stall is high, S1/S2/S3, `acc`, and the output register all hold.
  - `rdy_o = ~stall`. This is a combinational path from `rdy_i` and is permitted.
- When not stalled, `vld_o` clears after a handshake unless a new last beat loads the output register in the same cycle.

## Timing
- Reset values: `vld_o`=0, `result_o`=0, `rdy_o`=1 (since `vld_o`=0), all stage valids 0, `acc`=0.
- Latency: a last beat accepted in cycle t gives `vld_o`=1 in cycle t+3, provided there are no stalls. Each stall cycle adds one cycle.
- Throughput: one beat per cycle, and one result per cycle for consecutive one-beat vectors when `rdy_i`=1.
- `result_o` is stable while `vld_o & ~rdy_i`.
- A beat on `neuron_i`/`weight_i`/`ctl_i`/`mode_i` is sampled only when `vld_i & rdy_o`. Beats with `vld_i`=0 have no effect.
- Reset asserted mid-vector or mid-stall discards all in-flight beats and the held result. The cycle after `rst` deasserts, the reset values above apply.
- When a handshake on `result_o` and a new result load occur in the same cycle, the new result appears the next cycle with `vld_o` held at 1. No result is lost or duplicated.

## Test plan
1. LANES=4, one-beat vector, neurons {1,2,3,4}, weights {5,6,7,8}, mode 0 → `result_o`=70 (0x00000046), `vld_o` high exactly 3 cycles after the beat.
2. Three-beat vector with all elements 0x7FFF:
   - mode 0 → 0xFFF4000C (wrap).
   - same stimulus, mode 1 → 0x7FFFFFFF.
   - three beats of neurons −32768, weights 32767, mode 1 → 0x80000000.
3. One-beat vector, neurons all −1, weights all 100:
   - mode 1 → 0xFFFFFE70 (−400).
   - mode 2 → 0x00000000.
   - `mode_i` changed to 0 on a non-first beat of a multi-beat vector → ignored.
4. Stream 8 consecutive one-beat vectors with `rdy_i`=1 → 8 results on 8 consecutive cycles. Repeat with `rdy_i` low for 5 cycles after the first `vld_o` →
   - `rdy_o` low in the same cycles.
   - `result_o` held stable.
   - after release, all 8 results arrive in order with none lost or duplicated.
5. Reset for 1 cycle after 2 beats of a 4-beat vector → next cycle `vld_o`=0 and `rdy_o`=1. A new one-beat vector {1,1,1,1}·{1,1,1,1} then gives `result_o`=4, with no residue from the aborted vector.
6. Back-to-back 2-beat vectors (first/last adjacent with no gap, each beat {1,2,3,4}·{1,1,1,1}) → results 20, 20, with the second not including the first's accumulator.
